// File: rtl/execute_mul_pipe_pkg.sv
// Shared constants and helpers for the execute multiply pipe.
package execute_mul_pipe_pkg;

    localparam logic [1:0] CMD_MULL  = 2'd0;
    localparam logic [1:0] CMD_MULH  = 2'd1;
    localparam logic [1:0] CMD_UMULL = 2'd2;
    localparam logic [1:0] CMD_UMULH = 2'd3;

    // Bit positions inside the {SF,OF,CF,PF,ZF} flag word
    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 0;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
    } s1_t;

    function automatic logic cmd_is_signed(input logic [1:0] cmd);
        return (cmd == CMD_MULL) || (cmd == CMD_MULH);
    endfunction

    function automatic logic cmd_is_high(input logic [1:0] cmd);
        return (cmd == CMD_MULH) || (cmd == CMD_UMULH);
    endfunction

    function automatic logic [4:0] make_flags(input logic [31:0] word, input logic ovf);
        logic [4:0] f;
        f          = '0;
        f[FLAG_SF] = word[31];
        f[FLAG_OF] = ovf;
        f[FLAG_CF] = 1'b0;
        f[FLAG_PF] = word[0];
        f[FLAG_ZF] = (word == 32'd0);
        return f;
    endfunction

endpackage

// File: rtl/execute_mul_pipe_booth.sv
// Combinational 32x32 unsigned radix-4 Booth multiplier with low-word flags.
module mul_booth32
    import execute_mul_pipe_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product,
    output logic [4:0]  flags
);

    logic [65:0] acc;
    logic [65:0] pp;
    logic [65:0] a_x1;
    logic [65:0] a_x2;
    logic [34:0] b_ext;
    logic [2:0]  digit;

    // Sum 17 Booth partial products; b is zero-extended so the top digit is never negative
    always_comb begin
        acc   = '0;
        pp    = '0;
        digit = '0;
        a_x1  = {34'd0, a};
        a_x2  = {33'd0, a, 1'b0};
        b_ext = {2'b00, b, 1'b0};
        for (int i = 0; i < 17; i++) begin
            digit = b_ext[2*i+2 -: 3];
            case (digit)
                3'b001, 3'b010: pp = a_x1;
                3'b011:         pp = a_x2;
                3'b100:         pp = ~a_x2 + 66'd1;
                3'b101, 3'b110: pp = ~a_x1 + 66'd1;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        product = acc[63:0];
        flags   = make_flags(acc[31:0], acc[63:32] != 32'd0);
    end

endmodule

// File: rtl/execute_mul_pipe.sv
// Two-stage multiply pipe: S1 holds operands, S2 holds the selected word and flags.
module execute_mul_pipe
    import execute_mul_pipe_pkg::*;
(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iREQ_VALID,
    output logic        oREQ_BUSY,
    input  logic [1:0]  iREQ_CMD,
    input  logic [31:0] iREQ_DATA_0,
    input  logic [31:0] iREQ_DATA_1,
    input  logic [4:0]  iREQ_DEST,
    output logic        oOUT_VALID,
    input  logic        iOUT_BUSY,
    output logic [31:0] oOUT_DATA,
    output logic [4:0]  oOUT_FLAGS,
    output logic [4:0]  oOUT_DEST
);

    logic        s1_valid;
    s1_t         s1_q;
    logic        s2_valid;
    logic [31:0] s2_data;
    logic [4:0]  s2_flags;
    logic [4:0]  s2_dest;

    logic        s2_ready;
    logic        req_busy;

    logic        signed_mode;
    logic        negate;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] raw_product;
    logic [63:0] product;
    logic [31:0] selected;
    logic        ovf;
    logic [4:0]  flags_next;
    logic [4:0]  booth_flags_unused;

    assign s2_ready  = !s2_valid || !iOUT_BUSY;
    assign req_busy  = s1_valid && !s2_ready;

    // Signed operands become magnitudes; 0x80000000 maps to 2^31, which fits the unsigned 32-bit path
    always_comb begin
        signed_mode = cmd_is_signed(s1_q.cmd);
        mag_a       = (signed_mode && s1_q.a[31]) ? (~s1_q.a + 32'd1) : s1_q.a;
        mag_b       = (signed_mode && s1_q.b[31]) ? (~s1_q.b + 32'd1) : s1_q.b;
        negate      = signed_mode && (s1_q.a[31] ^ s1_q.b[31]);
    end

    mul_booth32 u_booth (
        .a       (mag_a),
        .b       (mag_b),
        .product (raw_product),
        .flags   (booth_flags_unused)
    );

    // Sign fix-up, word select and flag generation
    always_comb begin
        product = negate ? (~raw_product + 64'd1) : raw_product;
        if (cmd_is_high(s1_q.cmd)) begin
            selected = product[63:32];
            ovf      = 1'b0;
        end else begin
            selected = product[31:0];
            if (signed_mode)
                ovf = !((product[63:31] == 33'd0) || (product[63:31] == {33{1'b1}}));
            else
                ovf = (product[63:32] != 32'd0);
        end
        flags_next = make_flags(selected, ovf);
    end

    // S1: capture accepted requests, hold while S2 is stalled
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (iFLUSH) begin
            s1_valid <= 1'b0;
        end else if (!req_busy) begin
            s1_valid <= iREQ_VALID;
            if (iREQ_VALID)
                s1_q <= '{cmd: iREQ_CMD, a: iREQ_DATA_0, b: iREQ_DATA_1, dest: iREQ_DEST};
        end
    end

    // S2: load from S1 when empty or draining, hold while downstream is busy
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_flags <= '0;
            s2_dest  <= '0;
        end else if (iFLUSH) begin
            s2_valid <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data  <= selected;
                s2_flags <= flags_next;
                s2_dest  <= s1_q.dest;
            end
        end
    end

    assign oREQ_BUSY  = req_busy;
    assign oOUT_VALID = s2_valid;
    assign oOUT_DATA  = s2_data;
    assign oOUT_FLAGS = s2_flags;
    assign oOUT_DEST  = s2_dest;

endmodule

// File: tb/tb_execute_mul_pipe.sv
// Directed bench for execute_mul_pipe: inputs driven and outputs sampled on the falling edge.
module tb_execute_mul_pipe;

    logic        iCLOCK;
    logic        iRESET_SYNC;
    logic        iFLUSH;
    logic        iREQ_VALID;
    logic        oREQ_BUSY;
    logic [1:0]  iREQ_CMD;
    logic [31:0] iREQ_DATA_0;
    logic [31:0] iREQ_DATA_1;
    logic [4:0]  iREQ_DEST;
    logic        oOUT_VALID;
    logic        iOUT_BUSY;
    logic [31:0] oOUT_DATA;
    logic [4:0]  oOUT_FLAGS;
    logic [4:0]  oOUT_DEST;

    int vectors    = 0;
    int miscompares = 0;

    execute_mul_pipe dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iFLUSH      (iFLUSH),
        .iREQ_VALID  (iREQ_VALID),
        .oREQ_BUSY   (oREQ_BUSY),
        .iREQ_CMD    (iREQ_CMD),
        .iREQ_DATA_0 (iREQ_DATA_0),
        .iREQ_DATA_1 (iREQ_DATA_1),
        .iREQ_DEST   (iREQ_DEST),
        .oOUT_VALID  (oOUT_VALID),
        .iOUT_BUSY   (iOUT_BUSY),
        .oOUT_DATA   (oOUT_DATA),
        .oOUT_FLAGS  (oOUT_FLAGS),
        .oOUT_DEST   (oOUT_DEST)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic [1:0] cmd, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] dest);
        iREQ_VALID  = v;
        iREQ_CMD    = cmd;
        iREQ_DATA_0 = a;
        iREQ_DATA_1 = b;
        iREQ_DEST   = dest;
    endtask

    // One isolated operation: checks the empty pipe during S1 and the result 2 cycles after acceptance
    task automatic run_op(input string tag, input logic [1:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dest,
                          input logic [31:0] exp_data, input logic [4:0] exp_flags);
        @(negedge iCLOCK);
        drive_req(1'b1, cmd, a, b, dest);
        #1;
        check({tag, "_busy"}, {31'd0, oREQ_BUSY}, 32'd0);
        @(negedge iCLOCK);
        drive_req(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check({tag, "_early"}, {31'd0, oOUT_VALID}, 32'd0);
        @(negedge iCLOCK);
        #1;
        check({tag, "_valid"}, {31'd0, oOUT_VALID}, 32'd1);
        check({tag, "_data"},  oOUT_DATA, exp_data);
        check({tag, "_flags"}, {27'd0, oOUT_FLAGS}, {27'd0, exp_flags});
        check({tag, "_dest"},  {27'd0, oOUT_DEST}, {27'd0, dest});
    endtask

    initial begin : stim
        int next_req;
        int received;
        int busy_left;
        bit first_seen;
        bit busy_seen;
        bit busy_at_first;

        iRESET_SYNC = 1'b1;
        iFLUSH      = 1'b0;
        iOUT_BUSY   = 1'b0;
        drive_req(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        repeat (2) @(negedge iCLOCK);
        #1;
        check("rst_valid", {31'd0, oOUT_VALID}, 32'd0);
        check("rst_busy",  {31'd0, oREQ_BUSY}, 32'd0);
        check("rst_data",  oOUT_DATA, 32'd0);
        check("rst_flags", {27'd0, oOUT_FLAGS}, 32'd0);
        check("rst_dest",  {27'd0, oOUT_DEST}, 32'd0);
        iRESET_SYNC = 1'b0;

        // flags are {SF,OF,CF,PF,ZF}
        run_op("mull_3_m2",    2'd0, 32'h00000003, 32'hFFFFFFFE, 5'd1,  32'hFFFFFFFA, 5'b10000);
        run_op("umulh_ff",     2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 5'b10000);
        run_op("umull_ff",     2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000001, 5'b01010);
        run_op("mulh_min",     2'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 5'b00000);
        run_op("mull_min",     2'd0, 32'h80000000, 32'h80000000, 5'd5,  32'h00000000, 5'b01001);
        run_op("mull_7_6",     2'd0, 32'h00000007, 32'h00000006, 5'd6,  32'h0000002A, 5'b00000);
        run_op("mulh_m1_1",    2'd1, 32'hFFFFFFFF, 32'h00000001, 5'd7,  32'hFFFFFFFF, 5'b10010);
        run_op("mull_2p32",    2'd0, 32'h00010000, 32'h00010000, 5'd8,  32'h00000000, 5'b01001);
        run_op("mull_min_1",   2'd0, 32'h80000000, 32'h00000001, 5'd9,  32'h80000000, 5'b10000);
        run_op("mull_min_m1",  2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 5'b11000);
        run_op("umulh_small",  2'd3, 32'h00001234, 32'h00005678, 5'd11, 32'h00000000, 5'b00001);

        // Four back-to-back requests, downstream busy for 3 cycles starting at the first result
        @(negedge iCLOCK);
        next_req      = 0;
        received      = 0;
        busy_left     = 0;
        first_seen    = 1'b0;
        busy_seen     = 1'b0;
        busy_at_first = 1'b0;
        for (int cyc = 0; cyc < 30 && received < 4; cyc++) begin
            if (oOUT_VALID && !first_seen) begin
                first_seen = 1'b1;
                busy_left  = 3;
            end
            iOUT_BUSY = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (next_req < 4)
                drive_req(1'b1, 2'd2, 32'(next_req + 1), 32'd10, 5'(next_req + 20));
            else
                drive_req(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
            #1;
            if (oREQ_BUSY) busy_seen = 1'b1;
            if (oOUT_VALID && first_seen && received == 0 && iOUT_BUSY) busy_at_first = oREQ_BUSY;
            if (oOUT_VALID && !iOUT_BUSY) begin
                check("b2b_dest", {27'd0, oOUT_DEST}, 32'(received + 20));
                check("b2b_data", oOUT_DATA, 32'((received + 1) * 10));
                received++;
            end
            if (iREQ_VALID && !oREQ_BUSY) next_req++;
            @(negedge iCLOCK);
        end
        iOUT_BUSY = 1'b0;
        drive_req(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        check("b2b_count",      received, 32'd4);
        check("b2b_busy_seen",  {31'd0, busy_seen}, 32'd1);
        check("b2b_busy_first", {31'd0, busy_at_first}, 32'd1);
        #1;
        check("b2b_drained", {31'd0, oOUT_VALID}, 32'd0);

        // Three requests with no stall must emit on three consecutive cycles
        @(negedge iCLOCK);
        drive_req(1'b1, 2'd0, 32'd2, 32'd3, 5'd12);
        @(negedge iCLOCK);
        drive_req(1'b1, 2'd0, 32'd4, 32'd5, 5'd13);
        @(negedge iCLOCK);
        drive_req(1'b1, 2'd0, 32'd6, 32'd7, 5'd14);
        #1;
        check("stream_d0", {27'd0, oOUT_DEST}, 32'd12);
        check("stream_v0", {31'd0, oOUT_VALID}, 32'd1);
        @(negedge iCLOCK);
        drive_req(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("stream_v1", {31'd0, oOUT_VALID}, 32'd1);
        check("stream_x1", oOUT_DATA, 32'd20);
        @(negedge iCLOCK);
        #1;
        check("stream_v2", {31'd0, oOUT_VALID}, 32'd1);
        check("stream_x2", oOUT_DATA, 32'd42);

        // Flush with both stages full; the request presented during flush is dropped
        @(negedge iCLOCK);
        drive_req(1'b1, 2'd2, 32'd5, 32'd5, 5'd15);
        @(negedge iCLOCK);
        drive_req(1'b1, 2'd2, 32'd6, 32'd6, 5'd16);
        @(negedge iCLOCK);
        iOUT_BUSY = 1'b1;
        iFLUSH    = 1'b1;
        drive_req(1'b1, 2'd2, 32'd7, 32'd7, 5'd17);
        #1;
        check("flush_full", {31'd0, oOUT_VALID}, 32'd1);
        check("flush_busy", {31'd0, oREQ_BUSY}, 32'd1);
        @(negedge iCLOCK);
        iFLUSH    = 1'b0;
        iOUT_BUSY = 1'b0;
        drive_req(1'b1, 2'd2, 32'd9, 32'd9, 5'd18);
        #1;
        check("flush_out",   {31'd0, oOUT_VALID}, 32'd0);
        check("flush_rbusy", {31'd0, oREQ_BUSY}, 32'd0);
        @(negedge iCLOCK);
        drive_req(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("flush_s1", {31'd0, oOUT_VALID}, 32'd0);
        @(negedge iCLOCK);
        #1;
        check("flush_new_v", {31'd0, oOUT_VALID}, 32'd1);
        check("flush_new_t", {27'd0, oOUT_DEST}, 32'd18);
        check("flush_new_d", oOUT_DATA, 32'd81);
        @(negedge iCLOCK);
        #1;
        check("flush_empty", {31'd0, oOUT_VALID}, 32'd0);

        // Reset while S2 holds a stalled result and S1 is full
        @(negedge iCLOCK);
        drive_req(1'b1, 2'd0, 32'd3, 32'd3, 5'd21);
        @(negedge iCLOCK);
        drive_req(1'b1, 2'd0, 32'd4, 32'd4, 5'd22);
        @(negedge iCLOCK);
        drive_req(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        iOUT_BUSY   = 1'b1;
        iRESET_SYNC = 1'b1;
        iFLUSH      = 1'b1;
        #1;
        check("rst2_pre", {31'd0, oOUT_VALID}, 32'd1);
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        iFLUSH      = 1'b0;
        iOUT_BUSY   = 1'b0;
        #1;
        check("rst2_valid", {31'd0, oOUT_VALID}, 32'd0);
        check("rst2_busy",  {31'd0, oREQ_BUSY}, 32'd0);
        check("rst2_data",  oOUT_DATA, 32'd0);
        check("rst2_flags", {27'd0, oOUT_FLAGS}, 32'd0);
        check("rst2_dest",  {27'd0, oOUT_DEST}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLOCK);
            #1;
            check("rst2_stale", {31'd0, oOUT_VALID}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
